puzzle_engine: RTL and testbench

- Game engine for the 2x2 sliding puzzle. It sits directly downstream of the board-selection stage and consumes its 12-bit board word.
- It owns the game_status state machine that the board-selection stage reads. It loads the chosen board and applies one-step moves of the blank tile.
- It counts moves, detects the solved arrangement, and drives board/status to the display logic.

---
 rtl/puzzle_if.sv | 34 +++
 rtl/puzzle_engine.sv | 150 +++++++++++++++
 tb/tb_puzzle_engine.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/puzzle_if.sv
// Board/button/status bundle between the selection stage, the
// puzzle engine and the display logic.
interface puzzle_if #(
    parameter int unsigned CNT_W = 10
);
    logic [11:0]      board_in;
    logic             start;
    logic             abort;
    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic [1:0]       game_status;
    logic [11:0]      cur_board;
    logic [1:0]       blank_pos;
    logic [CNT_W-1:0] move_cnt;
    logic             moved;
    logic             illegal;
    logic             load_err;

    modport master (
        output board_in, start, abort,
        output btn_up, btn_down, btn_left, btn_right,
        input  game_status, cur_board, blank_pos,
        input  move_cnt, moved, illegal, load_err
    );

    modport slave (
        input  board_in, start, abort,
        input  btn_up, btn_down, btn_left, btn_right,
        output game_status, cur_board, blank_pos,
        output move_cnt, moved, illegal, load_err
    );
endinterface

// File: rtl/puzzle_engine.sv
// 2x2 sliding puzzle engine: loads a board, moves the blank,
// counts moves and detects the solved arrangement.
module puzzle_engine #(
    parameter logic [11:0] SOLVED = 12'h053,
    parameter int unsigned CNT_W  = 10
) (
    input logic     clk_d,
    input logic     rst,
    puzzle_if.slave bus
);
    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } state_t;

    state_t           state_q;
    logic [11:0]      board_q;
    logic [1:0]       blank_q;
    logic [CNT_W-1:0] cnt_q;
    logic             moved_q;
    logic             illegal_q;
    logic             lerr_q;

    logic [2:0]       fld [4];
    logic             in_valid;
    logic [1:0]       in_blank;
    logic [3:0]       btn;
    logic             legal;
    logic [1:0]       tgt;
    logic [11:0]      board_d;
    logic [CNT_W-1:0] cnt_d;

    assign btn = {bus.btn_up, bus.btn_down,
                  bus.btn_left, bus.btn_right};

    // Field i of the incoming word; pos0 sits in the top bits.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fld[i] = bus.board_in[9-3*i +: 3];
        end
    end

    always_comb begin
        in_valid = !fld[0][2] && !fld[1][2] &&
                   !fld[2][2] && !fld[3][2] &&
                   (fld[0] != fld[1]) && (fld[0] != fld[2]) &&
                   (fld[0] != fld[3]) && (fld[1] != fld[2]) &&
                   (fld[1] != fld[3]) && (fld[2] != fld[3]);
        in_blank = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (fld[i] == 3'd0) begin
                in_blank = 2'(i);
            end
        end
    end

    // Index bit 1 is the row, bit 0 the column.
    always_comb begin
        legal = 1'b0;
        tgt   = blank_q;
        case (btn)
            4'b1000: begin
                legal = blank_q[1];
                tgt   = blank_q - 2'd2;
            end
            4'b0100: begin
                legal = !blank_q[1];
                tgt   = blank_q + 2'd2;
            end
            4'b0010: begin
                legal = blank_q[0];
                tgt   = blank_q - 2'd1;
            end
            4'b0001: begin
                legal = !blank_q[0];
                tgt   = blank_q + 2'd1;
            end
            default: ;
        endcase
        board_d = board_q;
        board_d[9-3*int'(blank_q) +: 3] =
            board_q[9-3*int'(tgt) +: 3];
        board_d[9-3*int'(tgt) +: 3] = 3'd0;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            state_q   <= CHOSE_BOARD;
            board_q   <= SOLVED;
            blank_q   <= 2'd0;
            cnt_q     <= '0;
            moved_q   <= 1'b0;
            illegal_q <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            moved_q   <= 1'b0;
            illegal_q <= 1'b0;
            lerr_q    <= 1'b0;
            unique case (state_q)
                CHOSE_BOARD: begin
                    if (bus.start) begin
                        if (in_valid) begin
                            state_q <= GAME_INITIAL;
                        end else begin
                            lerr_q <= 1'b1;
                        end
                    end
                end
                GAME_INITIAL: begin
                    board_q <= bus.board_in;
                    blank_q <= in_blank;
                    cnt_q   <= '0;
                    state_q <= GAMING;
                end
                GAMING: begin
                    if (bus.abort) begin
                        state_q <= CHOSE_BOARD;
                    end else if (board_q == SOLVED) begin
                        state_q <= WINNED;
                    end else if ($onehot(btn)) begin
                        if (legal) begin
                            board_q <= board_d;
                            blank_q <= tgt;
                            cnt_q   <= cnt_d;
                            moved_q <= 1'b1;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                WINNED: begin
                    if (bus.abort || bus.start) begin
                        state_q <= CHOSE_BOARD;
                    end
                end
            endcase
        end
    end

    assign bus.game_status = state_q;
    assign bus.cur_board   = board_q;
    assign bus.blank_pos   = blank_q;
    assign bus.move_cnt    = cnt_q;
    assign bus.moved       = moved_q;
    assign bus.illegal     = illegal_q;
    assign bus.load_err    = lerr_q;
endmodule

// File: tb/tb_puzzle_engine.sv
// Bench for puzzle_engine: load table, hand-written games and a
// random run against a grid-level game model (CNT_W=10 and 2).
module tb_puzzle_engine;
    logic clk_d = 1'b0;
    logic rst;
    always #5 clk_d = ~clk_d;

    puzzle_if #(.CNT_W(10)) b10();
    puzzle_if #(.CNT_W(2))  b2();

    puzzle_engine #(.SOLVED(12'h053), .CNT_W(10)) dut10 (
        .clk_d(clk_d), .rst(rst), .bus(b10)
    );
    puzzle_engine #(.SOLVED(12'h053), .CNT_W(2)) dut2 (
        .clk_d(clk_d), .rst(rst), .bus(b2)
    );

    assign b2.board_in  = b10.board_in;
    assign b2.start     = b10.start;
    assign b2.abort     = b10.abort;
    assign b2.btn_up    = b10.btn_up;
    assign b2.btn_down  = b10.btn_down;
    assign b2.btn_left  = b10.btn_left;
    assign b2.btn_right = b10.btn_right;

    int checks = 0;
    int failures = 0;

    // Model: status code, tiles per cell, blank cell, unbounded count.
    int m_st;
    int m_brd [4];
    int m_blank;
    int m_cnt;
    bit m_mv, m_il, m_le;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic int field(input logic [11:0] w, input int i);
        return int'(w[9-3*i +: 3]);
    endfunction

    function automatic bit word_ok(input logic [11:0] w);
        bit seen [4];
        for (int i = 0; i < 4; i++) seen[i] = 0;
        for (int i = 0; i < 4; i++) begin
            int v = field(w, i);
            if (v > 3 || seen[v]) return 0;
            seen[v] = 1;
        end
        return 1;
    endfunction

    function automatic int m_word();
        return (m_brd[0] << 9) | (m_brd[1] << 6) |
               (m_brd[2] << 3) | m_brd[3];
    endfunction

    task automatic model_step();
        int nb;
        m_mv = 0; m_il = 0; m_le = 0;
        if (rst) begin
            m_st = 0; m_blank = 0; m_cnt = 0;
            m_brd = '{0, 1, 2, 3};
            return;
        end
        case (m_st)
            0: if (b10.start) begin
                if (word_ok(b10.board_in)) m_st = 2;
                else m_le = 1;
            end
            2: begin
                for (int i = 0; i < 4; i++) begin
                    m_brd[i] = field(b10.board_in, i);
                    if (m_brd[i] == 0) m_blank = i;
                end
                m_cnt = 0;
                m_st = 1;
            end
            1: begin
                nb = int'(b10.btn_up) + int'(b10.btn_down) +
                     int'(b10.btn_left) + int'(b10.btn_right);
                if (b10.abort) m_st = 0;
                else if (m_word() == 12'h053) m_st = 3;
                else if (nb == 1) begin
                    int r = m_blank / 2;
                    int c = m_blank % 2;
                    if (b10.btn_up) r--;
                    if (b10.btn_down) r++;
                    if (b10.btn_left) c--;
                    if (b10.btn_right) c++;
                    if (r >= 0 && r <= 1 && c >= 0 && c <= 1) begin
                        int q = r * 2 + c;
                        m_brd[m_blank] = m_brd[q];
                        m_brd[q] = 0;
                        m_blank = q;
                        m_cnt++;
                        m_mv = 1;
                    end else begin
                        m_il = 1;
                    end
                end
            end
            default: if (b10.abort || b10.start) m_st = 0;
        endcase
    endtask

    task automatic compare_all();
        chk("status", int'(b10.game_status), m_st);
        chk("board", int'(b10.cur_board), m_word());
        chk("blank", int'(b10.blank_pos), m_blank);
        chk("cnt10", int'(b10.move_cnt), (m_cnt > 1023) ? 1023 : m_cnt);
        chk("moved", int'(b10.moved), int'(m_mv));
        chk("illegal", int'(b10.illegal), int'(m_il));
        chk("load_err", int'(b10.load_err), int'(m_le));
        chk("status2", int'(b2.game_status), m_st);
        chk("board2", int'(b2.cur_board), m_word());
        chk("cnt2", int'(b2.move_cnt), (m_cnt > 3) ? 3 : m_cnt);
    endtask

    task automatic clear_in();
        rst = 0;
        b10.start = 0; b10.abort = 0;
        b10.btn_up = 0; b10.btn_down = 0;
        b10.btn_left = 0; b10.btn_right = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk_d);
        #1;
        compare_all();
        clear_in();
    endtask

    task automatic load(input logic [11:0] w);
        b10.board_in = w; b10.start = 1; step();
        step();
    endtask

    typedef struct {
        logic [11:0] word;
        bit          ok;
        int          blank;
    } vec_t;
    vec_t vt [6];

    initial begin
        vt[0] = '{12'h213, 1, 1};
        vt[1] = '{12'h05A, 1, 0};
        vt[2] = '{12'h013, 0, 0};
        vt[3] = '{12'h053, 1, 0};
        vt[4] = '{12'h688, 1, 3};
        vt[5] = '{12'h853, 0, 0};

        clear_in();
        b10.board_in = 12'h000;
        rst = 1; step();
        rst = 1; step();
        chk("rst_status", int'(b10.game_status), 0);
        chk("rst_board", int'(b10.cur_board), 12'h053);

        for (int i = 0; i < 10; i++) begin
            {b10.btn_up, b10.btn_down, b10.btn_left, b10.btn_right}
                = 4'($urandom);
            b10.abort = 1'($urandom);
            step();
            chk("idle_moved", int'(b10.moved), 0);
        end

        b10.board_in = 12'h213; b10.start = 1; step();
        chk("gi_status", int'(b10.game_status), 2);
        step();
        chk("gaming", int'(b10.game_status), 1);
        chk("gi_blank", int'(b10.blank_pos), 1);
        b10.btn_left = 1; step();
        chk("win_board", int'(b10.cur_board), 12'h053);
        chk("win_moved", int'(b10.moved), 1);
        chk("win_cnt", int'(b10.move_cnt), 1);
        b10.btn_up = 1; step();
        chk("winned", int'(b10.game_status), 3);
        b10.start = 1; step();
        chk("ack", int'(b10.game_status), 0);
        chk("ack_cnt", int'(b10.move_cnt), 1);

        load(12'h05A);
        b10.btn_up = 1; step();
        chk("ill_pulse", int'(b10.illegal), 1);
        chk("ill_board", int'(b10.cur_board), 12'h05A);
        b10.btn_left = 1; b10.btn_down = 1; step();
        chk("amb_pulse", int'(b10.moved | b10.illegal), 0);
        b10.btn_right = 1; step();
        chk("r_board", int'(b10.cur_board), 12'h21A);
        chk("r_blank", int'(b10.blank_pos), 1);
        chk("r_cnt", int'(b10.move_cnt), 1);
        b10.abort = 1; b10.start = 1; step();
        chk("abort", int'(b10.game_status), 0);
        chk("abort_cnt", int'(b10.move_cnt), 1);

        b10.board_in = 12'h013; b10.start = 1; step();
        chk("lerr", int'(b10.load_err), 1);
        chk("lerr_st", int'(b10.game_status), 0);
        chk("lerr_board", int'(b10.cur_board), 12'h21A);

        load(12'h05A);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) b10.btn_right = 1;
            else b10.btn_left = 1;
            step();
        end
        chk("sat10", int'(b10.move_cnt), 5);
        chk("sat2", int'(b2.move_cnt), 3);
        rst = 1; b10.btn_left = 1; step();
        chk("mid_rst_st", int'(b10.game_status), 0);
        chk("mid_rst_bd", int'(b10.cur_board), 12'h053);
        chk("mid_rst_cnt", int'(b10.move_cnt), 0);
        chk("mid_rst_mv", int'(b10.moved), 0);

        foreach (vt[i]) begin
            b10.board_in = vt[i].word; b10.start = 1; step();
            chk("tbl_lerr", int'(b10.load_err), int'(!vt[i].ok));
            if (vt[i].ok) begin
                step();
                chk("tbl_blank", int'(b10.blank_pos), vt[i].blank);
                chk("tbl_cnt", int'(b10.move_cnt), 0);
                step();
                chk("tbl_st", int'(b10.game_status),
                    (vt[i].word == 12'h053) ? 3 : 1);
                b10.abort = 1; step();
            end
        end

        for (int n = 0; n < 600; n++) begin
            if (m_st == 0) begin
                if ($urandom_range(0, 5) == 0) begin
                    b10.board_in = 12'($urandom);
                end else begin
                    int p [4] = '{0, 1, 2, 3};
                    for (int k = 3; k > 0; k--) begin
                        int j = $urandom_range(0, k);
                        int t = p[k];
                        p[k] = p[j]; p[j] = t;
                    end
                    b10.board_in = 12'((p[0] << 9) | (p[1] << 6) |
                                       (p[2] << 3) | p[3]);
                end
            end
            b10.start = ($urandom_range(0, 3) == 0);
            b10.abort = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 5))
                0: b10.btn_up = 1;
                1: b10.btn_down = 1;
                2: b10.btn_left = 1;
                3: b10.btn_right = 1;
                4: begin b10.btn_up = 1; b10.btn_right = 1; end
                default: ;
            endcase
            rst = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
